// File: rtl/chan_select_pktz.sv
// chan_select_pktz: keeps channelizer samples whose channel is enabled in the settings mask, repacketizes them into SPP-sample packets.
// Latency: a selected sample appears on out_tdata one cycle after it is accepted.
// Backpressure: in_tready falls when the 2-entry output FIFO is full, regardless of whether the next sample would be kept.
//
// Optional feature macro: CHAN_SEL_TAG_EN adds out_tuser (7-bit channel index per output sample).
// Ports:
//   ce_clk, ce_rst_n                  clock, asynchronous active-low reset
//   set_stb, set_addr, set_data       settings bus (mask words at SR_MASK_BASE.., SPP at SR_SPP)
//   in_tdata/in_tlast/in_tvalid/in_tready     channel-interleaved frames from the channelizer
//   out_tdata/out_tlast/out_tvalid/out_tready packetized selected samples
//   err_cnt                           saturating frame-alignment error count
//   out_tuser (CHAN_SEL_TAG_EN only)  channel index of the output sample

// chan_select_pktz_fifo2: 2-entry registered FIFO.
// Latency: pushed data is at the head on the cycle after the push.
// Backpressure: a push is taken when not full, or when full and popping in the same cycle.
module chan_select_pktz_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

module chan_select_pktz #(
    parameter int         NUM_CHAN     = 128,
    parameter int         WIDTH        = 32,
    parameter logic [7:0] SR_MASK_BASE = 8'd136,
    parameter logic [7:0] SR_SPP       = 8'd140,
    parameter int         SPP_DEFAULT  = 64
) (
    input  logic             ce_clk,
    input  logic             ce_rst_n,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tlast,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tlast,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [15:0]      err_cnt
`ifdef CHAN_SEL_TAG_EN
    ,
    output logic [6:0]       out_tuser
`endif
);

    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int MW = (NUM_CHAN + 31) / 32;
    localparam int MB = MW * 32;
`ifdef CHAN_SEL_TAG_EN
    localparam int FW = WIDTH + 1 + 7;
`else
    localparam int FW = WIDTH + 1;
`endif

    logic [MB-1:0] mask_stage;
    logic [MB-1:0] mask_act;
    logic [15:0]   spp_stage;
    logic [15:0]   spp_act;
    logic [15:0]   spp_eff;
    logic [15:0]   pkt_cnt;
    logic [CW-1:0] chan_cnt;
    logic          rdy_en;
    logic [1:0]    fifo_cnt;
    logic [FW-1:0] push_dat;
    logic [FW-1:0] head_dat;
    logic          accept;
    logic          sel;
    logic          push;
    logic          pkt_last;
    logic          last_chan;
    logic          align_err;

    // Held low through reset and for the first edge after it, so nothing is
    // accepted before the settings and counters are known-good.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    assign in_tready = rdy_en && (fifo_cnt != 2'd2);
    assign accept    = in_tvalid && in_tready;
    assign sel       = mask_act[chan_cnt];
    assign push      = accept && sel;
    assign last_chan = (chan_cnt == CW'(NUM_CHAN - 1));
    // Early last and missing last are both alignment errors.
    assign align_err = accept && (in_tlast != last_chan);

    // While no packet is open the staged SPP is already the one in force, so
    // the first sample of a new packet is judged against the new length.
    assign spp_eff  = (pkt_cnt == 16'd0) ? spp_stage : spp_act;
    assign pkt_last = (pkt_cnt == spp_eff - 16'd1);

    // Settings staging registers.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            mask_stage <= '1;
            spp_stage  <= 16'(SPP_DEFAULT);
        end else if (set_stb) begin
            for (int k = 0; k < MW; k++) begin
                if (set_addr == SR_MASK_BASE + 8'(k)) begin
                    mask_stage[k*32 +: 32] <= set_data;
                end
            end
            if (set_addr == SR_SPP) begin
                spp_stage <= (set_data[15:0] == 16'd0) ? 16'd1 : set_data[15:0];
            end
        end
    end

    // Active settings: mask swaps only on an accepted in_tlast so a frame never
    // sees a mixed mask; SPP swaps only between packets.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            mask_act <= '1;
            spp_act  <= 16'(SPP_DEFAULT);
        end else begin
            if (accept && in_tlast) begin
                mask_act <= mask_stage;
            end
            if (pkt_cnt == 16'd0) begin
                spp_act <= spp_stage;
            end
        end
    end

    // Channel position, packet position and alignment error counting.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            chan_cnt <= '0;
            pkt_cnt  <= 16'd0;
            err_cnt  <= 16'd0;
        end else begin
            if (accept) begin
                chan_cnt <= (in_tlast || last_chan) ? '0 : chan_cnt + CW'(1);
            end
            if (push) begin
                pkt_cnt <= pkt_last ? 16'd0 : pkt_cnt + 16'd1;
            end
            if (align_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

`ifdef CHAN_SEL_TAG_EN
    assign push_dat = {7'(chan_cnt), pkt_last, in_tdata};
    assign out_tuser = head_dat[WIDTH+1 +: 7];
`else
    assign push_dat = {pkt_last, in_tdata};
`endif

    chan_select_pktz_fifo2 #(
        .W (FW)
    ) u_fifo (
        .clk      (ce_clk),
        .rst_n    (ce_rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (out_tready),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    assign out_tvalid = (fifo_cnt != 2'd0);
    assign out_tdata  = head_dat[WIDTH-1:0];
    assign out_tlast  = head_dat[WIDTH];

endmodule
